gfx_fetch_buf: RTL and testbench

- Buffers graphics ROM byte reads from the vball video core's gfx port (gfx_addr/gfx_read/gfx_data) to the SDRAM controller's rd/ready/dout port.
- Queues requests in a small FIFO and serves repeated addresses from a last-address hit register without touching SDRAM.
- Enforces a per-read timeout so a stalled SDRAM never freezes video.
- While a ROM download is in progress, SDRAM is yielded entirely to the download path.

---
 rtl/gfx_fetch_buf.sv | 158 +++++++++++++++
 tb/tb_gfx_fetch_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_fetch_buf.sv
// Graphics ROM fetch buffer between the video core's gfx port and the SDRAM read port.
// Requests are queued, repeated addresses are served from a one-entry hit register, and every read has a timeout.
module gfx_fetch_buf #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 19,
  parameter logic [24:0] BASE    = 25'h0,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl,
  input  logic          req,
  input  logic [AW-1:0] req_addr,
  output logic [7:0]    rsp_data,
  output logic          rsp_valid,
  output logic          full,
  output logic [24:0]   sd_addr,
  output logic          sd_rd,
  input  logic          sd_ready,
  input  logic [7:0]    sd_dout,
  output logic [7:0]    err_cnt,
  output logic [1:0]    dbg_state_o
);

  // Handshake: req is a one-cycle strobe accepted only while full=0 and dl=0 (no retry),
  // rsp_valid is a one-cycle pulse in request order, sd_rd is a one-cycle strobe answered by a sd_ready pulse.

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q;
  logic [AW-1:0]  head;
  logic           push, pop, hit, tmo_hit;
  logic [TW-1:0]  tmo_q;
  logic           hit_valid_q;
  logic [AW-1:0]  hit_addr_q, cur_addr_q;
  logic [7:0]     hit_data_q, rsp_data_q, err_cnt_q;
  logic [24:0]    sd_addr_q;

  assign head    = mem_q[rd_ptr_q];
  assign push    = req && !full_q && !dl;
  assign pop     = (state_q == IDLE) && (count_q != '0) && !dl;
  assign hit     = hit_valid_q && (head == hit_addr_q);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (dl) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = hit ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sd_ready || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sd_rd       = (state_q == ISSUE);
    rsp_valid   = (state_q == RESP);
    dbg_state_o = state_q;
  end

  // Payload storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= req_addr;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (dl) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q  <= '0;
      sd_addr_q   <= '0;
      rsp_data_q  <= '0;
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_data_q  <= '0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (pop) begin
        if (hit) begin
          rsp_data_q <= hit_data_q;
        end else begin
          cur_addr_q <= head;
          sd_addr_q  <= BASE + 25'(head);
        end
      end
      if (state_q == ISSUE) tmo_q <= '0;
      if (state_q == WAIT) begin
        if (sd_ready) begin
          rsp_data_q  <= sd_dout;
          hit_addr_q  <= cur_addr_q;
          hit_data_q  <= sd_dout;
          hit_valid_q <= 1'b1;
        end else if (tmo_hit) begin
          rsp_data_q <= 8'hFF;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
      // ROM contents may be rewritten during a download, so the cached byte is stale.
      if (dl) hit_valid_q <= 1'b0;
    end
  end

  assign rsp_data = rsp_data_q;
  assign full     = full_q;
  assign sd_addr  = sd_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gfx_fetch_buf.sv
// Directed bench for gfx_fetch_buf: miss, hit, backpressure, timeout, download and async reset scenarios.
module tb_gfx_fetch_buf;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl = 1'b0;
  logic        req = 1'b0;
  logic [18:0] req_addr = '0;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        full;
  logic [24:0] sd_addr;
  logic        sd_rd;
  logic        sd_ready = 1'b0;
  logic [7:0]  sd_dout;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  bit          dout_by_addr = 1'b0;
  logic [7:0]  dout_fixed = 8'h00;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  rsp_q[$];
  int          rsp_cyc_q[$];
  logic [24:0] rd_addr_q[$];
  logic [7:0]  exp_q[$];

  gfx_fetch_buf dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl(dl), .req(req), .req_addr(req_addr),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .full(full), .sd_addr(sd_addr),
    .sd_rd(sd_rd), .sd_ready(sd_ready), .sd_dout(sd_dout), .err_cnt(err_cnt),
    .dbg_state_o(dbg_state)
  );

  // Clock and SDRAM data model
  always #5 clk_sys = ~clk_sys;
  always_comb sd_dout = dout_by_addr ? sd_addr[7:0] : dout_fixed;

  always @(posedge clk_sys) begin
    if (rsp_valid === 1'b1) begin
      rsp_q.push_back(rsp_data);
      rsp_cyc_q.push_back(cyc);
    end
    if (sd_rd === 1'b1) rd_addr_q.push_back(sd_addr);
    cyc = cyc + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_mon();
    rsp_q.delete();
    rsp_cyc_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic do_req(input logic [18:0] a);
    req = 1'b1;
    req_addr = a;
    tick();
    req = 1'b0;
  endtask

  task automatic pulse_ready();
    sd_ready = 1'b1;
    tick();
    sd_ready = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (sd_rd === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_rsp(input int n, input int max, output bit ok);
    for (int i = 0; i < max && rsp_q.size() < n; i++) tick();
    ok = (rsp_q.size() >= n);
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (sd_addr !== 25'h0) begin failures++; $display("FAIL reset_sd_addr got=%h exp=0", sd_addr); end
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL reset_sd_rd got=%b exp=0", sd_rd); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_miss();
    int n;
    bit ok;
    logic [7:0] got;
    clear_mon();
    dout_by_addr = 1'b0;
    dout_fixed = 8'h5A;
    n = cyc;
    do_req(19'h00123);
    wait_rd(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL miss_sd_rd got=none exp=pulse"); end
    checks++; if (sd_addr !== 25'h000123) begin failures++; $display("FAIL miss_sd_addr got=%h exp=000123", sd_addr); end
    checks++; if (cyc !== n + 2) begin failures++; $display("FAIL miss_issue_cycle got=%0d exp=%0d", cyc - n, 2); end
    repeat (5) tick();
    pulse_ready();
    wait_rsp(1, 20, ok);
    got = ok ? rsp_q[0] : 8'hxx;
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL miss_rsp_data got=%h exp=5a", got); end
    checks++; if ((ok ? rsp_cyc_q[0] - n : -1) !== 8) begin failures++; $display("FAIL miss_latency got=%0d exp=8", ok ? rsp_cyc_q[0] - n : -1); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL miss_err_cnt got=%h exp=00", err_cnt); end
  endtask

  task automatic test_hit();
    int n;
    logic [7:0] got;
    clear_mon();
    dout_fixed = 8'h00;
    n = cyc;
    do_req(19'h00123);
    repeat (4) tick();
    got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL hit_rsp_count got=%0d exp=1", rsp_q.size()); end
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL hit_rsp_data got=%h exp=5a", got); end
    checks++; if ((rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - n : -1) !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - n : -1); end
    checks++; if (rd_addr_q.size() !== 0) begin failures++; $display("FAIL hit_no_sd_rd got=%0d exp=0", rd_addr_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [24:0] first_rd;
    clear_mon();
    exp_q.delete();
    sd_ready = 1'b0;
    dout_by_addr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req = 1'b1;
      req_addr = 19'h00010 + 19'(i);
      tick();
    end
    req = 1'b0;
    tick();
    first_rd = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 25'hx;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_full got=%b exp=1", full); end
    checks++; if (rd_addr_q.size() !== 1) begin failures++; $display("FAIL bp_rd_before_release got=%0d exp=1", rd_addr_q.size()); end
    checks++; if (first_rd !== 25'h000010) begin failures++; $display("FAIL bp_first_addr got=%h exp=000010", first_rd); end
    sd_ready = 1'b1;
    wait_rsp(5, 100, ok);
    repeat (10) tick();
    sd_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
    checks++; if (rsp_q.size() !== 5) begin failures++; $display("FAIL bp_rsp_count got=%0d exp=5", rsp_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((i < rsp_q.size() ? rsp_q[i] : 8'hxx) !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_rsp_order[%0d] got=%h exp=%h", i, i < rsp_q.size() ? rsp_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (rd_addr_q.size() !== 5) begin failures++; $display("FAIL bp_rd_count got=%0d exp=5", rd_addr_q.size()); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL bp_full_cleared got=%b exp=0", full); end
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    bit ok;
    logic [7:0] e255;
    logic [7:0] got;
    clear_mon();
    dout_by_addr = 1'b0;
    dout_fixed = 8'h00;
    sd_ready = 1'b0;
    n = cyc;
    do_req(19'h00200);
    wait_rsp(1, 200, ok);
    got = ok ? rsp_q[0] : 8'hxx;
    checks++; if (got !== 8'hFF) begin failures++; $display("FAIL tmo_rsp_data got=%h exp=ff", got); end
    checks++; if ((ok ? rsp_cyc_q[0] - n : -1) !== 67) begin failures++; $display("FAIL tmo_latency got=%0d exp=67", ok ? rsp_cyc_q[0] - n : -1); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL tmo_err_cnt got=%0d exp=1", err_cnt); end
    bad = 0;
    e255 = 8'h00;
    for (int k = 2; k <= 260; k++) begin
      clear_mon();
      do_req(19'h00200);
      wait_rsp(1, 200, ok);
      if (!ok || rsp_q[0] !== 8'hFF) bad++;
      if (k == 255) e255 = err_cnt;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL tmo_repeat_rsp got=%0d_bad exp=0", bad); end
    checks++; if (e255 !== 8'd255) begin failures++; $display("FAIL tmo_err_at_255 got=%0d exp=255", e255); end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL tmo_err_saturate got=%0d exp=255", err_cnt); end
  endtask

  task automatic test_download();
    bit ok;
    logic [7:0] got;
    clear_mon();
    dout_by_addr = 1'b1;
    sd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      req_addr = 19'h00030 + 19'(i);
      tick();
    end
    req = 1'b0;
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL dl_in_wait got=%0d exp=2", dbg_state); end
    dl = 1'b1;
    req = 1'b1;
    req_addr = 19'h00040;
    tick();
    req = 1'b0;
    repeat (3) tick();
    pulse_ready();
    repeat (10) tick();
    got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL dl_rsp_count got=%0d exp=1", rsp_q.size()); end
    checks++; if (got !== 8'h30) begin failures++; $display("FAIL dl_rsp_data got=%h exp=30", got); end
    dl = 1'b0;
    repeat (10) tick();
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL dl_no_more_rsp got=%0d exp=1", rsp_q.size()); end
    checks++; if (rd_addr_q.size() !== 1) begin failures++; $display("FAIL dl_no_more_rd got=%0d exp=1", rd_addr_q.size()); end
    clear_mon();
    do_req(19'h00014);
    wait_rd(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dl_rehit_misses got=none exp=sd_rd"); end
    checks++; if (sd_addr !== 25'h000014) begin failures++; $display("FAIL dl_rehit_addr got=%h exp=000014", sd_addr); end
    tick();
    pulse_ready();
    wait_rsp(1, 20, ok);
    got = ok ? rsp_q[0] : 8'hxx;
    checks++; if (got !== 8'h14) begin failures++; $display("FAIL dl_rehit_data got=%h exp=14", got); end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [7:0] got;
    clear_mon();
    dout_by_addr = 1'b1;
    sd_ready = 1'b0;
    do_req(19'h00050);
    do_req(19'h00051);
    wait_rd(ok);
    tick();
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL ar_in_wait got=%0d exp=2", dbg_state); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL ar_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ar_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (sd_addr !== 25'h0) begin failures++; $display("FAIL ar_sd_addr got=%h exp=0", sd_addr); end
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL ar_sd_rd got=%b exp=0", sd_rd); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL ar_err_cnt got=%h exp=00", err_cnt); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL ar_state got=%0d exp=0", dbg_state); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    clear_mon();
    repeat (80) tick();
    checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL ar_stale_rsp got=%0d exp=0", rsp_q.size()); end
    checks++; if (rd_addr_q.size() !== 0) begin failures++; $display("FAIL ar_fifo_empty got=%0d exp=0", rd_addr_q.size()); end
    do_req(19'h00060);
    wait_rd(ok);
    tick();
    pulse_ready();
    wait_rsp(1, 20, ok);
    got = ok ? rsp_q[0] : 8'hxx;
    checks++; if (got !== 8'h60) begin failures++; $display("FAIL ar_after_release got=%h exp=60", got); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_back_to_back();
    test_timeout();
    test_download();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
